// File: rtl/pc_ctrl_if.sv
// Control/status bundle between a sequencer and the pc_ctrl program counter.
// BrCount exists only when PC_CTRL_BRCNT_EN is defined.
interface pc_ctrl_if #(
    parameter int PC_W = 10
);
    logic            Start;
    logic            Halt;
    logic            Stall;
    logic            BranchEn;
    logic            Taken;
    logic [1:0]      LutIdx;
    logic [1:0]      LutAddr;
    logic [PC_W-1:0] LutTarget;
    logic [PC_W-1:0] PC;
    logic            FetchValid;
    logic            Done;
`ifdef PC_CTRL_BRCNT_EN
    logic [15:0]     BrCount;

    modport master (
        output Start, Halt, Stall, BranchEn, Taken, LutIdx, LutTarget,
        input  LutAddr, PC, FetchValid, Done, BrCount
    );
    modport slave (
        input  Start, Halt, Stall, BranchEn, Taken, LutIdx, LutTarget,
        output LutAddr, PC, FetchValid, Done, BrCount
    );
`else
    modport master (
        output Start, Halt, Stall, BranchEn, Taken, LutIdx, LutTarget,
        input  LutAddr, PC, FetchValid, Done
    );
    modport slave (
        input  Start, Halt, Stall, BranchEn, Taken, LutIdx, LutTarget,
        output LutAddr, PC, FetchValid, Done
    );
`endif
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: IDLE/RUN/BRANCH/DONE with one-cycle branch bubble.
// Define PC_CTRL_BRCNT_EN to add the saturating BrCount branch counter.
module pc_ctrl #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input logic       Clk,
    input logic       Reset,
    pc_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BRANCH,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [1:0]      lut_addr;
    logic            fetch_valid;
    logic            done;
    logic            pc_load;
    logic            pc_inc;
    logic            pc_redirect;
    logic            lut_load;
    logic            taken;

    assign taken = bus.BranchEn && bus.Taken;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.Start) state_nxt = RUN;
            end
            RUN: begin
                if (bus.Halt)       state_nxt = DONE;
                else if (bus.Stall) state_nxt = RUN;
                else if (taken)     state_nxt = BRANCH;
                else                state_nxt = RUN;
            end
            BRANCH: begin
                state_nxt = RUN;
            end
            DONE: begin
                if (bus.Start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fetch_valid = 1'b0;
        done        = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_redirect = 1'b0;
        lut_load    = 1'b0;
        unique case (state)
            IDLE: begin
                pc_load = bus.Start;
            end
            RUN: begin
                fetch_valid = 1'b1;
                lut_load    = !bus.Halt && !bus.Stall && taken;
                pc_inc      = !bus.Halt && !bus.Stall && !taken;
            end
            BRANCH: begin
                pc_redirect = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                pc_load = bus.Start;
            end
            default: ;
        endcase
    end

    // LutTarget is a two's-complement offset, so plain modular addition covers negative jumps
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc       <= START_ADDR;
            lut_addr <= '0;
        end else begin
            if (pc_load)          pc <= START_ADDR;
            else if (pc_inc)      pc <= pc + PC_W'(1);
            else if (pc_redirect) pc <= pc + bus.LutTarget;
            if (lut_load) lut_addr <= bus.LutIdx;
        end
    end

    assign bus.PC         = pc;
    assign bus.LutAddr    = lut_addr;
    assign bus.FetchValid = fetch_valid;
    assign bus.Done       = done;

`ifdef PC_CTRL_BRCNT_EN
    logic [15:0] br_count;

    always_ff @(posedge Clk) begin
        if (Reset || pc_load) begin
            br_count <= '0;
        end else if (lut_load && (br_count != '1)) begin
            br_count <= br_count + 16'd1;
        end
    end

    assign bus.BrCount = br_count;
`endif

endmodule
